// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares one register-file read port among four requesters. Stage 1 picks a
// round-robin winner and registers its register select. Stage 2 captures the
// mux output one cycle later and returns it tagged with the winner's ID.
//
// Handshake: req is a level request. gnt[w] pulses for one cycle per accepted
// read. A req bit still high at the edge after its gnt counts as a new request.
// rvalid pulses exactly one cycle after the matching gnt, with rid == w.
module regfile_read_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [19:0]  req_addr,
  input  logic         hold,
  output logic [3:0]   gnt,
  output logic [4:0]   Read_Register,
  input  logic [N-1:0] Read_Data,
  output logic [N-1:0] rdata,
  output logic         rvalid,
  output logic [1:0]   rid
);

  // Round-robin pointer: requester with highest priority this cycle.
  logic [1:0]   ptr_q, ptr_d;
  // Stage-1 registers.
  logic [3:0]   gnt_q, gnt_d;
  logic [4:0]   rreg_q, rreg_d;
  logic         s1_valid_q, s1_valid_d;
  logic [1:0]   s1_id_q, s1_id_d;
  // Stage-2 registers.
  logic [N-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;
  logic [1:0]   rid_q, rid_d;

  // Winner search, scanning from the pointer upward (mod 4).
  logic         win_found;
  logic [1:0]   win_id;
  logic [1:0]   scan_idx;

  // Pick the first requesting index in the order p, p+1, p+2, p+3.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    scan_idx  = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Next-state for both pipeline stages and the pointer.
  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = 4'b0000;
    rreg_d     = rreg_q;
    s1_valid_d = 1'b0;
    s1_id_d    = s1_id_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    rid_d      = rid_q;

    if (!hold && win_found) begin
      ptr_d      = win_id + 2'd1;
      gnt_d      = 4'b0001 << win_id;
      rreg_d     = req_addr[5*win_id +: 5];
      s1_valid_d = 1'b1;
      s1_id_d    = win_id;
    end

    // Stage 2 is never stalled by hold: an issued grant always completes.
    if (s1_valid_q) begin
      rdata_d  = Read_Data;
      rid_d    = s1_id_q;
      rvalid_d = 1'b1;
    end
  end

  // State registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      rreg_q     <= 5'd0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 2'd0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rid_q      <= 2'd0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rreg_q     <= rreg_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rid_q      <= rid_d;
    end
  end

  assign gnt           = gnt_q;
  assign Read_Register = rreg_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign rid           = rid_q;

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Round-robin arbiter and sequencer for one register-file read port. It shares the port among four requesters (for example fetch/decode operand A, operand B, debug and trace). Each cycle it selects one requester and drives the 5-bit register select into the 32:1 read mux. It then captures the mux output one cycle later and returns it tagged with the requester ID. It sits between the requesting pipeline units and the register-file read mux.

## Interface
- N, 32, data width; must match the read mux width.
- Requester count is fixed at 4. Requester IDs are 0..3.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Asserting 0 clears all state immediately.
- req  in  4  level request, one bit per requester.
- req_addr  in  20  register index per requester; requester i uses bits [5i+4:5i].
- hold  in  1  when 1 at a clock edge, no new grant is issued.
- gnt  out  4  one-hot grant; high for exactly one cycle.
- Read_Register  out  5  registered select driven into the read mux.
- Read_Data  in  N  combinational data returned by the read mux.
- rdata  out  N  captured read data.
- rvalid  out  1  rdata/rid valid; one-cycle pulse per grant.
- rid  out  2  requester ID that owns rdata.

## Operation
- Two-stage pipeline.
  - Stage 1 (arbitrate/select): at clock edge E0, if hold=0 and any req bit is 1, choose winner w by round robin. Register the following:
    - Read_Register <= req_addr[w]
    - gnt <= onehot(w)
    - s1_valid <= 1
    - s1_id <= w
  - Otherwise: gnt <= 0 and s1_valid <= 0. Read_Register keeps its old value.
  - Stage 2 (capture): at edge E1, if s1_valid=1, register the following:
    - rdata <= Read_Data
    - rid <= s1_id
    - rvalid <= 1
  - Otherwise rvalid <= 0. rdata and rid hold their values.
- Round robin uses a 2-bit pointer p.
  - Priority order is p, p+1, p+2, p+3 (mod 4).
  - After a grant to w, p <= (w+1) mod 4.
  - p is unchanged when nothing is granted, including all hold cycles.
- Request rule: a req bit still high at the edge after its gnt counts as a new request, with its then-current req_addr. A requester wanting exactly one read must drop req in the cycle gnt is seen.
- At most one grant per cycle. Sustained throughput is one read per cycle.
- Address width: all 32 indices are legal, including 0. This block applies no special handling to register 0.
- hold does not flush stage 2. A grant issued before hold asserted still produces its rvalid.
- Simultaneous hold=1 and req: no grant; requests stay pending (level-based). Nothing is lost.
- Reset values: p=0, meaning requester 0 has highest priority. Outputs reset as follows:
  - gnt=0
  - Read_Register=0
  - s1_valid=0
  - rvalid=0
  - rdata=0
  - rid=0
- Reset mid-operation discards any in-flight stage-1 or stage-2 transaction. No rvalid is produced for it after reset releases.

## Timing
- Latency:
  - gnt is high in the cycle after the sampling edge E0.
  - Read_Register changes at E0.
  - rvalid, rdata and rid are valid in the cycle after E1, which is 2 edges after the request is sampled.
- Read_Data is combinational from Read_Register. The mux path must settle within one cycle.
- gnt and rvalid for the same transaction are exactly one cycle apart. gnt[w] and rid=w correspond.
- No combinational path exists from req, req_addr or hold to any output. All outputs are registered.
- Back-to-back grants give back-to-back rvalid pulses with no bubbles.

## Test plan
- Reset: hold reset=0 with random inputs, then release -> the following all stay 0 until the first request:
  - gnt
  - rvalid
  - Read_Register
  - rdata
  - rid
- Single read: the mux reg 7 holds 0xDEADBEEF. req=0100 with addr2=7 for one cycle -> next cycle gnt=0100 and Read_Register=7. The following cycle rvalid=1, rid=2, rdata=0xDEADBEEF.
- Fairness: from reset, req=1111 continuously -> gnt sequence is 0001, 0010, 0100, 1000, 0001… with rvalid every cycle. rid follows 0,1,2,3,0 with one cycle of lag.
- Pointer skip: grant requester 0 (p becomes 1), then req=1001 -> requester 3 wins before requester 0.
- Hold: req=0010 with hold=1 for 3 cycles -> gnt=0 and no rvalid during hold. hold drops to 0 -> gnt=0010 next cycle, then rvalid with rid=1.
- Reset mid-flight: pulse reset low in the cycle gnt=0001 is high -> no rvalid ever appears for that grant. The next grant comes from requester 0 priority (p=0).
